exe_result_queue_arbiter: RTL and testbench
===========================================

Name: exe_result_queue_arbiter

Overview:
- Parametrised writeback arbiter between the function units and the ROB.
- Each FU response lane feeds a per-FU result FIFO instead of being claimed combinationally in the same cycle.
- Buffered results are packed into up to ewd execute slots per cycle under round-robin FU priority.
- Per-FU credit-style ready signals replace the per-lane claim handshake; a flush input discards all buffered results.

Parameters:
- nfu, 5, number of function units.
- fwd, 4, response lanes per function unit.
- ewd, 4, execute (writeback) slots toward the ROB.
- qdepth, 8, entries per FU FIFO; power of two, must be >= fwd.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all buffered results (pipeline redirect)
- fu_resp  in  exe_bundle_t [nfu-1:0][fwd-1:0]  FU responses; a lane is valid when opid[15]=1
- fu_ready  out  [nfu-1:0]  FU i may present responses this cycle
- execute  in  [ewd-1:0]  slot k may be filled this cycle
- exe_bundle  out  exe_bundle_t [ewd-1:0]  packed results to ROB
- overflow  out  [nfu-1:0]  sticky, FU i pushed into a full FIFO

Behaviour:
- FIFO i state: head pointer, tail pointer and count (0..qdepth). Pointers wrap modulo qdepth.
- fu_ready[i] = (qdepth - count[i]) >= fwd. It is combinational from registered count and does not depend on the same-cycle pop.
- Enqueue:
  - Valid lanes of fu_resp[i] are written in ascending lane index and compacted; invalid lanes leave no hole.
  - Write happens on the clock edge regardless of fu_ready.
  - Entries that would exceed qdepth are dropped and set overflow[i]; overflow clears only on rst.
- Latency: a result enqueued at edge N is eligible for exe_bundle in cycle N+1 at the earliest. There is no same-cycle bypass.
- Output packing (combinational from FIFO state, rr pointer and execute):
  - Set slot=0. Visit FUs in order rr, rr+1, ... mod nfu.
  - For each FU, take entries from its head in FIFO order while the FIFO has untaken entries, slot<ewd, and execute[slot]=1.
  - Each taken entry goes to exe_bundle[slot] and slot increments.
  - Packing stops entirely at the first slot with execute[slot]=0. Later slots stay zero even if their execute bit is 1.
  - Unfilled exe_bundle slots are all-zero (opid[15]=0).
- Dequeue: every entry placed in exe_bundle is popped at the clock edge; execute is the accept.
- Round-robin update:
  - If at least one entry was popped, rr <= (index of last FU that supplied an entry + 1) mod nfu.
  - Otherwise rr holds.
  - Guarantees every non-empty FIFO is served within nfu cycles while execute[0]=1.
- Count update: count <= count + enq - deq. Pop and push in the same cycle on a full FIFO is legal only up to the dropped-entry rule above; the capacity check uses the post-pop free space.
- flush (synchronous):
  - At the edge, all counts and pointers go to 0 and rr goes to 0.
  - Same-cycle fu_resp are dropped and same-cycle pops are discarded.
  - exe_bundle still shows entries combinationally during the flush cycle; the ROB is responsible for ignoring them.
  - overflow is unaffected.
- rst, including mid-operation: counts, pointers, rr and overflow all go to 0 at the edge. After reset, exe_bundle is all-zero and fu_ready is all-ones.

Test Plan:
- Single FU path: FU2 sends one valid lane (opid=16'h8005) with execute=4'hF. exe_bundle all-zero in that cycle; next cycle exe_bundle[0].opid=16'h8005; FIFO2 empty after that edge.
- Lane compaction: FU0 lanes {invalid, opid 8001, invalid, opid 8003}. Next cycle slots 0,1 carry 8001 and 8003 in that order.
- Round-robin: FU0 and FU1 each hold 4 results, execute=4'hF, rr=0.
  - Cycle A outputs FU0's 4 results; rr becomes 1.
  - Cycle B outputs FU1's 4 results; rr becomes 2.
- Execute gap: 3 buffered results with execute=4'b1101. Only slot 0 is filled; 1 entry popped, 2 remain.
- Backpressure and overflow:
  - qdepth=8, execute=0, FU3 pushes 4 valid results per cycle. fu_ready[3] drops after the second push (count=8).
  - A third push sets overflow[3]=1 and count stays 8.
- Flush and reset: with 6 entries buffered across FUs, assert flush for one cycle. Next cycle exe_bundle is all-zero and all fu_ready are 1. Repeat with rst; overflow also clears.

Source files
------------

// File: rtl/exe_result_queue_arbiter.sv
// Writeback arbiter: per-FU result FIFOs packed into ewd ROB slots under round-robin FU priority.
// Results appear one cycle after enqueue; fu_ready drops when a FIFO cannot absorb a full fwd-lane burst.
package exe_result_pkg;
  typedef struct packed {
    logic [15:0] opid;
    logic [31:0] data;
  } exe_bundle_t;
endpackage

module exe_result_queue_arbiter
  import exe_result_pkg::*;
#(
  parameter int nfu    = 5,
  parameter int fwd    = 4,
  parameter int ewd    = 4,
  parameter int qdepth = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  exe_bundle_t [nfu-1:0][fwd-1:0]   fu_resp,
  output logic [nfu-1:0]                   fu_ready,
  input  logic [ewd-1:0]                   execute,
  output exe_bundle_t [ewd-1:0]            exe_bundle,
  output logic [nfu-1:0]                   overflow
);

  localparam int FW = (nfu > 1) ? $clog2(nfu) : 1;
  localparam int PW = (qdepth > 1) ? $clog2(qdepth) : 1;
  localparam int CW = $clog2(qdepth + 1);

  exe_bundle_t    mem_q   [nfu][qdepth];
  exe_bundle_t    mem_d   [nfu][qdepth];
  logic [PW-1:0]  head_q  [nfu];
  logic [PW-1:0]  head_d  [nfu];
  logic [PW-1:0]  tail_q  [nfu];
  logic [PW-1:0]  tail_d  [nfu];
  logic [CW-1:0]  count_q [nfu];
  logic [CW-1:0]  count_d [nfu];
  logic [FW-1:0]  rr_q, rr_d;
  logic [nfu-1:0] overflow_q, overflow_d;

  logic [ewd-1:0] slot_vld;
  logic [FW-1:0]  slot_fu  [ewd];
  logic [PW-1:0]  slot_ptr [ewd];
  logic [CW-1:0]  deq      [nfu];
  logic           pop_any;
  logic [FW-1:0]  last_fu;

  // cap = leading run of execute ones; each FU in rr order fills the next contiguous slot range.
  always_comb begin
    int cap;
    int base;
    int taken;
    int fu_int;
    logic [FW-1:0] fu;
    slot_vld = '0;
    pop_any  = 1'b0;
    last_fu  = '0;
    for (int k = 0; k < ewd; k++) begin
      slot_fu[k]  = '0;
      slot_ptr[k] = '0;
    end
    for (int i = 0; i < nfu; i++) deq[i] = '0;
    cap = ewd;
    for (int k = ewd - 1; k >= 0; k--) begin
      if (!execute[k]) cap = k;
    end
    base = 0;
    for (int j = 0; j < nfu; j++) begin
      fu_int = int'(rr_q) + j;
      if (fu_int >= nfu) fu_int = fu_int - nfu;
      fu    = FW'(fu_int);
      taken = (cap > base) ? (cap - base) : 0;
      if (taken > int'(count_q[fu])) taken = int'(count_q[fu]);
      if (taken > 0) begin
        pop_any = 1'b1;
        last_fu = fu;
      end
      deq[fu] = CW'(taken);
      for (int k = 0; k < ewd; k++) begin
        if (k >= base && k < base + taken) begin
          slot_vld[k] = 1'b1;
          slot_fu[k]  = fu;
          slot_ptr[k] = PW'(int'(head_q[fu]) + k - base);
        end
      end
      base = base + taken;
    end
  end

  always_comb begin
    for (int k = 0; k < ewd; k++) begin
      exe_bundle[k] = slot_vld[k] ? mem_q[slot_fu[k]][slot_ptr[k]] : '0;
    end
    for (int i = 0; i < nfu; i++) begin
      fu_ready[i] = (qdepth - int'(count_q[i])) >= fwd;
    end
    overflow = overflow_q;
  end

  always_comb begin
    int nvalid;
    int free;
    int enq;
    mem_d      = mem_q;
    overflow_d = overflow_q;
    rr_d       = rr_q;
    if (pop_any) rr_d = (last_fu == FW'(nfu - 1)) ? '0 : last_fu + 1'b1;
    for (int i = 0; i < nfu; i++) begin
      nvalid = 0;
      // Capacity is judged after this cycle's pops have freed their entries.
      free = qdepth - int'(count_q[i]) + int'(deq[i]);
      for (int l = 0; l < fwd; l++) begin
        if (fu_resp[i][l].opid[15]) begin
          if (nvalid < free) mem_d[i][PW'(int'(tail_q[i]) + nvalid)] = fu_resp[i][l];
          nvalid = nvalid + 1;
        end
      end
      enq = (nvalid < free) ? nvalid : free;
      if (nvalid > free && !flush) overflow_d[i] = 1'b1;
      head_d[i]  = PW'(int'(head_q[i]) + int'(deq[i]));
      tail_d[i]  = PW'(int'(tail_q[i]) + enq);
      count_d[i] = CW'(int'(count_q[i]) - int'(deq[i]) + enq);
      if (flush) begin
        head_d[i]  = '0;
        tail_d[i]  = '0;
        count_d[i] = '0;
      end
    end
    if (flush) rr_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < nfu; i++) begin
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
        count_q[i] <= '0;
      end
      rr_q       <= '0;
      overflow_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      rr_q       <= rr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_exe_result_queue_arbiter.sv
// Scoreboarded bench: a queue-based reference model predicts each cycle's slots, readiness and overflow.
module tb_exe_result_queue_arbiter;
  import exe_result_pkg::*;

  localparam int NFU = 5;
  localparam int FWD = 4;
  localparam int EWD = 4;
  localparam int QD  = 8;

  typedef exe_bundle_t [NFU-1:0][FWD-1:0] resp_t;
  typedef struct { int cyc; int slot; exe_bundle_t b; } exp_res_t;
  typedef struct { int cyc; logic [NFU-1:0] rdy; logic [NFU-1:0] ovf; } exp_stat_t;

  logic                  clk;
  logic                  rst;
  logic                  flush;
  resp_t                 fu_resp;
  logic [NFU-1:0]        fu_ready;
  logic [EWD-1:0]        execute;
  exe_bundle_t [EWD-1:0] exe_bundle;
  logic [NFU-1:0]        overflow;

  exe_result_queue_arbiter #(.nfu(NFU), .fwd(FWD), .ewd(EWD), .qdepth(QD)) dut (
    .clk(clk), .rst(rst), .flush(flush), .fu_resp(fu_resp), .fu_ready(fu_ready),
    .execute(execute), .exe_bundle(exe_bundle), .overflow(overflow)
  );

  always #5 clk = ~clk;

  exp_res_t    res_q[$];
  exp_stat_t   stat_q[$];
  exe_bundle_t mq [NFU][$];
  int          rr_m;
  logic [NFU-1:0] ovf_m;
  int          cyc;
  int          n_checks;
  int          n_pass;

  function automatic exe_bundle_t mk(input logic [15:0] opid);
    exe_bundle_t b;
    b.opid = opid;
    b.data = $urandom;
    return b;
  endfunction

  // Predict this cycle's outputs from the model, then advance the model past the edge.
  task automatic step(input resp_t r, input logic [EWD-1:0] ex, input logic fl, input logic rs);
    exp_stat_t st;
    exp_res_t  e;
    int take [NFU];
    int slot, last, f;
    bit stop;
    fu_resp = r;
    execute = ex;
    flush   = fl;
    rst     = rs;
    st.cyc = cyc;
    for (int i = 0; i < NFU; i++) st.rdy[i] = (QD - mq[i].size()) >= FWD;
    st.ovf = ovf_m;
    stat_q.push_back(st);
    slot = 0;
    stop = 0;
    last = -1;
    for (int j = 0; j < NFU; j++) begin
      f = (rr_m + j) % NFU;
      take[f] = 0;
      while (!stop && take[f] < mq[f].size()) begin
        if (slot < EWD && ex[slot]) begin
          e.cyc  = cyc;
          e.slot = slot;
          e.b    = mq[f][take[f]];
          res_q.push_back(e);
          take[f]++;
          slot++;
          last = f;
        end else begin
          stop = 1;
        end
      end
    end
    if (rs) begin
      for (int i = 0; i < NFU; i++) mq[i].delete();
      rr_m  = 0;
      ovf_m = '0;
    end else if (fl) begin
      for (int i = 0; i < NFU; i++) mq[i].delete();
      rr_m = 0;
    end else begin
      for (int i = 0; i < NFU; i++) repeat (take[i]) void'(mq[i].pop_front());
      if (last >= 0) rr_m = (last + 1) % NFU;
      for (int i = 0; i < NFU; i++)
        for (int l = 0; l < FWD; l++)
          if (r[i][l].opid[15]) begin
            if (mq[i].size() < QD) mq[i].push_back(r[i][l]);
            else ovf_m[i] = 1'b1;
          end
    end
    cyc++;
    @(negedge clk);
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard, decoupled from stimulus.
  exp_stat_t st_m;
  exp_res_t  e_m;
  always @(negedge clk) begin
    #1;
    if (stat_q.size() > 0) begin
      st_m = stat_q.pop_front();
      n_checks++;
      if (fu_ready === st_m.rdy) n_pass++;
      else $display("FAIL fu_ready cyc=%0d got=%b exp=%b", st_m.cyc, fu_ready, st_m.rdy);
      n_checks++;
      if (overflow === st_m.ovf) n_pass++;
      else $display("FAIL overflow cyc=%0d got=%b exp=%b", st_m.cyc, overflow, st_m.ovf);
      for (int k = 0; k < EWD; k++) begin
        n_checks++;
        if (exe_bundle[k].opid[15] === 1'b1) begin
          if (res_q.size() == 0 || res_q[0].cyc != st_m.cyc) begin
            $display("FAIL slot_unexpected cyc=%0d slot=%0d got=%h exp=none", st_m.cyc, k, exe_bundle[k]);
          end else begin
            e_m = res_q.pop_front();
            if (e_m.slot == k && e_m.b === exe_bundle[k]) n_pass++;
            else $display("FAIL slot_data cyc=%0d slot=%0d got=%h exp=%h@slot%0d",
                          st_m.cyc, k, exe_bundle[k], e_m.b, e_m.slot);
          end
        end else if (exe_bundle[k] === '0) begin
          n_pass++;
        end else begin
          $display("FAIL slot_zero cyc=%0d slot=%0d got=%h exp=0", st_m.cyc, k, exe_bundle[k]);
        end
      end
      while (res_q.size() > 0 && res_q[0].cyc == st_m.cyc) begin
        e_m = res_q.pop_front();
        n_checks++;
        $display("FAIL slot_missing cyc=%0d slot=%0d got=%h exp=%h",
                 st_m.cyc, e_m.slot, exe_bundle[e_m.slot], e_m.b);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resp_t r;
    resp_t z;
    logic [EWD-1:0] ex;
    z = '0;
    clk = 0; rst = 1; flush = 0; execute = '0; fu_resp = '0;
    rr_m = 0; ovf_m = '0; cyc = 0; n_checks = 0; n_pass = 0;
    repeat (2) @(negedge clk);

    // Reset state, then single FU2 result with one-cycle latency.
    step(z, 4'hF, 0, 0);
    r = '0; r[2][0] = mk(16'h8005);
    step(r, 4'hF, 0, 0);
    step(z, 4'hF, 0, 0);
    step(z, 4'hF, 0, 0);

    // Lane compaction around invalid lanes.
    r = '0;
    r[0][0] = mk(16'h0123); r[0][1] = mk(16'h8001);
    r[0][2] = mk(16'h7fff); r[0][3] = mk(16'h8003);
    step(r, 4'hF, 0, 0);
    step(z, 4'hF, 0, 0);

    // Round-robin from rr=0 with FU0 and FU1 full bursts.
    step(z, 4'h0, 0, 1);
    r = '0;
    for (int l = 0; l < FWD; l++) begin
      r[0][l] = mk(16'h8100 + 16'(l));
      r[1][l] = mk(16'h8200 + 16'(l));
    end
    step(r, 4'h0, 0, 0);
    step(z, 4'hF, 0, 0);
    step(z, 4'hF, 0, 0);
    step(z, 4'hF, 0, 0);

    // Execute gap stops packing at slot 1.
    r = '0;
    for (int l = 0; l < 3; l++) r[4][l] = mk(16'h8400 + 16'(l));
    step(r, 4'h0, 0, 0);
    step(z, 4'b1101, 0, 0);
    step(z, 4'h0, 0, 0);
    step(z, 4'hF, 0, 0);

    // Backpressure and overflow on FU3.
    for (int p = 0; p < 3; p++) begin
      r = '0;
      for (int l = 0; l < FWD; l++) r[3][l] = mk(16'h8300 + 16'(p * 4 + l));
      step(r, 4'h0, 0, 0);
    end
    step(z, 4'h0, 0, 0);
    step(z, 4'hF, 0, 0);
    step(z, 4'hF, 0, 0);
    step(z, 4'hF, 0, 0);

    // Flush with six buffered entries, then the same with reset.
    for (int pass = 0; pass < 2; pass++) begin
      r = '0;
      r[0][0] = mk(16'h8500); r[0][2] = mk(16'h8501);
      r[1][0] = mk(16'h8510); r[1][1] = mk(16'h8511); r[1][3] = mk(16'h8512);
      r[4][1] = mk(16'h8540);
      step(r, 4'h0, 0, 0);
      step(z, 4'hF, pass == 0, pass == 1);
      step(z, 4'hF, 0, 0);
    end

    // Randomised traffic.
    for (int c = 0; c < 600; c++) begin
      r = '0;
      for (int i = 0; i < NFU; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          for (int l = 0; l < FWD; l++) begin
            if ($urandom_range(0, 1) == 1) r[i][l] = mk({1'b1, 15'($urandom)});
            else r[i][l] = mk({1'b0, 15'($urandom)});
          end
        end
      end
      ex = ($urandom_range(0, 3) == 0) ? EWD'($urandom) : '1;
      step(r, ex, $urandom_range(0, 39) == 0, $urandom_range(0, 99) == 0);
    end
    step(z, 4'hF, 0, 0);

    #3;
    while (res_q.size() > 0) begin
      e_m = res_q.pop_front();
      n_checks++;
      $display("FAIL leftover cyc=%0d slot=%0d got=none exp=%h", e_m.cyc, e_m.slot, e_m.b);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
